// File: rtl/layer_sequencer.sv
// Layer sequencer: runs a chain of conv layers one at a time and, between
// layers, copies the finished layer's output buffer into the next layer's
// input buffer, optionally applying ReLU on the way through.
module layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    // Entry k (bits [k*ADDR_W +: ADDR_W]) is the copy length from layer k to k+1
    parameter logic [ADDR_W*(NUM_LAYERS-1)-1:0] COPY_LEN = {16'd4096, 16'd16384}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  single,
    input  logic [2:0]            start_layer,
    input  logic                  relu_en,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] finish,
    output logic [NUM_LAYERS-1:0] en_conv,
    output logic [NUM_LAYERS-1:0] rd_sel,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [NUM_LAYERS-1:0] wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            layer_idx
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StCopy,
        StFlush,
        StDone
    } state_e;

    // Four bits so that NUM_LAYERS = 8 still compares correctly
    localparam logic [3:0]            NumLayersW = 4'(NUM_LAYERS);
    localparam logic [2:0]            LastIdx    = 3'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] OneHot0    = NUM_LAYERS'(1);

    state_e state_q;
    logic   single_q;

    logic                  start_ok;
    logic                  finish_hit;
    logic                  last_layer;
    logic [ADDR_W-1:0]     copy_last;

    // Start-request legality and completion of the active layer
    always_comb begin
        start_ok   = ({1'b0, start_layer} < NumLayersW);
        // Only the finish bit of the enabled layer counts
        finish_hit = |(finish & en_conv);
        last_layer = single_q || (layer_idx == LastIdx);
    end

    // Last read address of the copy out of the current layer
    always_comb begin
        copy_last = '0;
        for (int k = 0; k < NUM_LAYERS - 1; k++) begin
            if (layer_idx == 3'(k)) begin
                copy_last = COPY_LEN[k*ADDR_W +: ADDR_W] - ADDR_W'(1);
            end
        end
    end

    // Write data follows the buffer read data in the same cycle it becomes valid
    always_comb begin
        wr_data = '0;
        if (|wr_en) begin
            wr_data = (relu_en && rd_data[DATA_W-1]) ? '0 : rd_data;
        end
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            single_q  <= 1'b0;
            en_conv   <= '0;
            rd_sel    <= '0;
            rd_addr   <= '0;
            wr_en     <= '0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            layer_idx <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                // Abort wins over finish and copy progress; no done pulse
                state_q <= StIdle;
                en_conv <= '0;
                rd_sel  <= '0;
                rd_addr <= '0;
                wr_en   <= '0;
                wr_addr <= '0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (start_ok) begin
                                state_q   <= StRun;
                                en_conv   <= OneHot0 << start_layer;
                                layer_idx <= start_layer;
                                single_q  <= single;
                                busy      <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (finish_hit) begin
                            en_conv <= '0;
                            if (last_layer) begin
                                state_q <= StDone;
                            end else begin
                                state_q <= StCopy;
                                rd_sel  <= en_conv;
                                rd_addr <= '0;
                            end
                        end
                    end
                    StCopy: begin
                        // Write the word read last cycle into the next layer's buffer
                        wr_en   <= rd_sel << 1;
                        wr_addr <= rd_addr;
                        if (rd_addr == copy_last) begin
                            state_q <= StFlush;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                    StFlush: begin
                        // Final write is on the bus this cycle; hand over to next layer
                        wr_en     <= '0;
                        rd_sel    <= '0;
                        rd_addr   <= '0;
                        en_conv   <= rd_sel << 1;
                        layer_idx <= layer_idx + 3'd1;
                        state_q   <= StRun;
                    end
                    StDone: begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: random buffer contents and finish timing, checked
// against a list-based model of which writes and layer enables a run produces.
module tb_layer_sequencer;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 16;

    typedef struct packed {
        logic [2:0]  en;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          single = 1'b0;
    logic [2:0]    start_layer = 3'd0;
    logic          relu_en = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  finish = '0;
    logic [N-1:0]  en_conv, rd_sel, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] wr_data;
    logic          busy, done, err;
    logic [2:0]    layer_idx;
    logic [54:0]   outs_all;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] omem [0:2][0:15];

    layer_sequencer #(
        .NUM_LAYERS(N),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .COPY_LEN  ({16'd3, 16'd4})
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .single     (single),
        .start_layer(start_layer),
        .relu_en    (relu_en),
        .abort      (abort),
        .finish     (finish),
        .en_conv    (en_conv),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .layer_idx  (layer_idx)
    );

    always #5 clk = ~clk;

    assign outs_all = {en_conv, rd_sel, wr_en, rd_addr, wr_addr, wr_data,
                       busy, done, err, layer_idx};

    // Output buffers of the conv layers: one cycle read latency
    always @(posedge clk) begin
        case (rd_sel)
            3'b001:  rd_data <= omem[0][rd_addr[3:0]];
            3'b010:  rd_data <= omem[1][rd_addr[3:0]];
            3'b100:  rd_data <= omem[2][rd_addr[3:0]];
            default: rd_data <= '0;
        endcase
    end

    // Monitor: log writes, enable changes, pulses and invariant violations
    wr_t        wq[$];
    logic [2:0] enq[$];
    int         cyc = 0, done_cnt = 0, err_cnt = 0, viol_cnt = 0;
    int         fall_cyc = 0, done_cyc = 0;
    logic [2:0] prev_en = 3'b000;

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_en <= en_conv;
        if (|wr_en) wq.push_back('{en: wr_en, addr: wr_addr, data: wr_data});
        if (en_conv != 3'b000 && en_conv != prev_en) enq.push_back(en_conv);
        if (en_conv == 3'b000 && prev_en != 3'b000) fall_cyc <= cyc;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (!$onehot0(en_conv) || !$onehot0(wr_en) || (en_conv != 0 && wr_en != 0) ||
            (done && busy))
            viol_cnt <= viol_cnt + 1;
    end

    // Reference model results
    wr_t        exp_w[$];
    logic [2:0] exp_en[$];

    function automatic int copy_len(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic logic [7:0] relu_f(input logic [7:0] d, input logic r);
        if (r && $signed(d) < 0) return 8'h00;
        return d;
    endfunction

    task automatic model_run(input logic [2:0] sl, input logic sgl, input logic relu);
        logic [2:0] one;
        one = 3'b001;
        exp_w.delete();
        exp_en.delete();
        exp_en.push_back(one << sl);
        if (!sgl) begin
            for (int k = int'(sl); k < N - 1; k++) begin
                for (int i = 0; i < copy_len(k); i++)
                    exp_w.push_back('{en: one << (k + 1), addr: 16'(i),
                                      data: relu_f(omem[k][i], relu)});
                exp_en.push_back(one << (k + 1));
            end
        end
    endtask

    task automatic fill_mem();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) omem[k][i] = 8'($urandom);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Drive one run to completion, acting as the conv controllers' finish source
    task automatic do_run(input logic [2:0] sl, input logic sgl, input logic relu,
                          input int fix_dly, input bit spur, output bit timed_out);
        int cnt;
        bit armed;
        cnt = 0;
        armed = 0;
        @(negedge clk);
        start = 1'b1; start_layer = sl; single = sgl; relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (en_conv == 3'b000) begin
                finish = '0;
                armed = 0;
            end else if (!armed) begin
                armed = 1;
                cnt = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 12));
                finish = '0;
            end else if (cnt > 1) begin
                cnt--;
                finish = (spur && $urandom_range(0, 2) == 0) ? ~en_conv : 3'b000;
            end else begin
                finish = en_conv;
            end
            @(negedge clk);
        end
        finish = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b1; abort = 1'b1; finish = '1; start_layer = 3'd0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({en_conv, rd_sel, wr_en} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_enables: got %b want 0", {en_conv, rd_sel, wr_en});
        end
        n_cmp++;
        if ({rd_addr, wr_addr, wr_data, layer_idx} !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_addr_data: got %h want 0", {rd_addr, wr_addr, wr_data, layer_idx});
        end
        n_cmp++;
        if ({busy, done, err} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_status: got %b want 000", {busy, done, err});
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; finish = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, en_conv} !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_release_idle: got %b want 0", {busy, en_conv});
        end
    endtask

    task automatic test_chain();
        int w0, e0, d0, v0;
        bit to;
        logic relu;
        fill_mem();
        relu = 1'($urandom);
        settle();
        w0 = wq.size(); e0 = enq.size(); d0 = done_cnt; v0 = viol_cnt;
        do_run(3'd0, 1'b0, relu, 10, 1'b0, to);
        settle();
        settle();
        model_run(3'd0, 1'b0, relu);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL chain_timeout: got timeout want done"); end
        n_cmp++;
        if (enq.size() - e0 !== exp_en.size()) begin
            n_bad++;
            $display("FAIL chain_en_count: got %0d want %0d", enq.size() - e0, exp_en.size());
        end
        for (int i = 0; i < exp_en.size() && e0 + i < enq.size(); i++) begin
            n_cmp++;
            if (enq[e0 + i] !== exp_en[i]) begin
                n_bad++;
                $display("FAIL chain_en[%0d]: got %b want %b", i, enq[e0 + i], exp_en[i]);
            end
        end
        n_cmp++;
        if (wq.size() - w0 !== exp_w.size()) begin
            n_bad++;
            $display("FAIL chain_wr_count: got %0d want %0d", wq.size() - w0, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && w0 + i < wq.size(); i++) begin
            n_cmp++;
            if (wq[w0 + i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL chain_wr[%0d]: got %h want %h", i, wq[w0 + i], exp_w[i]);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL chain_done_pulses: got %0d want 1", done_cnt - d0);
        end
        n_cmp++;
        if (viol_cnt - v0 !== 0) begin
            n_bad++;
            $display("FAIL chain_invariants: got %0d violations want 0", viol_cnt - v0);
        end
    endtask

    task automatic test_relu();
        logic [7:0] pat [4];
        logic [7:0] clamped [4];
        int w0;
        bit to;
        pat = '{8'h05, 8'hF0, 8'h80, 8'h7F};
        clamped = '{8'h05, 8'h00, 8'h00, 8'h7F};
        for (int r = 0; r < 2; r++) begin
            fill_mem();
            for (int i = 0; i < 4; i++) omem[0][i] = pat[i];
            settle();
            w0 = wq.size();
            do_run(3'd0, 1'b0, 1'(r), 3, 1'b0, to);
            settle();
            settle();
            n_cmp++;
            if (wq.size() - w0 < 4) begin
                n_bad++;
                $display("FAIL relu%0d_count: got %0d want >=4", r, wq.size() - w0);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    n_cmp++;
                    if ({wq[w0 + i].addr, wq[w0 + i].data} !==
                        {16'(i), (r == 1) ? clamped[i] : pat[i]}) begin
                        n_bad++;
                        $display("FAIL relu%0d_wr[%0d]: got %h/%h want %h/%h", r, i,
                                 wq[w0 + i].addr, wq[w0 + i].data, i,
                                 (r == 1) ? clamped[i] : pat[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_single();
        int w0, e0, d0;
        bit to;
        fill_mem();
        settle();
        w0 = wq.size(); e0 = enq.size(); d0 = done_cnt;
        do_run(3'd1, 1'b1, 1'($urandom), 0, 1'b0, to);
        settle();
        settle();
        n_cmp++;
        if (to || enq.size() - e0 !== 1) begin
            n_bad++;
            $display("FAIL single_en_count: got %0d want 1 (timeout=%0d)", enq.size() - e0, to);
        end else begin
            n_cmp++;
            if (enq[e0] !== 3'b010) begin
                n_bad++;
                $display("FAIL single_en: got %b want 010", enq[e0]);
            end
        end
        n_cmp++;
        if (wq.size() - w0 !== 0) begin
            n_bad++;
            $display("FAIL single_writes: got %0d want 0", wq.size() - w0);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL single_done_pulses: got %0d want 1", done_cnt - d0);
        end
        n_cmp++;
        if (done_cyc - fall_cyc !== 1) begin
            n_bad++;
            $display("FAIL single_done_latency: got %0d want 1", done_cyc - fall_cyc);
        end
    endtask

    task automatic test_bad_start();
        logic [2:0] bad [3];
        int er0, d0;
        bad = '{3'd5, 3'd3, 3'd7};
        settle();
        er0 = err_cnt; d0 = done_cnt;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            start = 1'b1; start_layer = bad[j]; single = 1'b0;
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if ({err, busy, en_conv} !== 5'b10000) begin
                n_bad++;
                $display("FAIL bad_start%0d: got err,busy,en=%b want 10000", bad[j],
                         {err, busy, en_conv});
            end
            @(negedge clk);
            n_cmp++;
            if ({err, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL bad_start%0d_pulse_end: got %b want 00", bad[j], {err, busy});
            end
        end
        // Start while busy must not retarget the run
        @(negedge clk);
        start = 1'b1; start_layer = 3'd0; single = 1'b0; relu_en = 1'b0;
        @(negedge clk);
        start_layer = 3'd2;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({en_conv, layer_idx, busy} !== {3'b001, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL start_while_busy: got en=%b idx=%0d busy=%b want 001/0/1",
                     en_conv, layer_idx, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        settle();
        n_cmp++;
        if (err_cnt - er0 !== 3) begin
            n_bad++;
            $display("FAIL bad_start_err_pulses: got %0d want 3", err_cnt - er0);
        end
        n_cmp++;
        if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_abort: got done=%0d busy=%b want 0/0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_abort();
        int w0, d0;
        bit found, to;
        fill_mem();
        settle();
        w0 = wq.size(); d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; start_layer = 3'd0; single = 1'b0; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0; finish = 3'b001;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (en_conv == 3'b000) finish = '0;
            if (rd_addr == 16'd2 && rd_sel != 3'b000) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL abort_reach_addr2: got timeout want addr 2"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({en_conv, wr_en, rd_sel, busy, done} !== 11'd0) begin
            n_bad++;
            $display("FAIL abort_copy_outputs: got %b want 0", {en_conv, wr_en, rd_sel, busy, done});
        end
        // Abort together with finish in RUN: abort wins, no copy starts
        @(negedge clk);
        start = 1'b1; start_layer = 3'd0; single = 1'b0;
        @(negedge clk);
        start = 1'b0; finish = 3'b001; abort = 1'b1;
        @(negedge clk);
        finish = '0; abort = 1'b0;
        n_cmp++;
        if ({en_conv, rd_sel, busy} !== 7'd0) begin
            n_bad++;
            $display("FAIL abort_vs_finish: got %b want 0", {en_conv, rd_sel, busy});
        end
        repeat (5) @(negedge clk);
        settle();
        n_cmp++;
        if (done_cnt - d0 !== 0 || wq.size() - w0 !== 2) begin
            n_bad++;
            $display("FAIL abort_no_done: got done=%0d writes=%0d want 0/2", done_cnt - d0,
                     wq.size() - w0);
        end
        // A fresh run after abort behaves normally
        w0 = wq.size(); d0 = done_cnt;
        do_run(3'd0, 1'b0, 1'b1, 0, 1'b0, to);
        settle();
        settle();
        model_run(3'd0, 1'b0, 1'b1);
        n_cmp++;
        if (to || done_cnt - d0 !== 1 || wq.size() - w0 !== exp_w.size()) begin
            n_bad++;
            $display("FAIL abort_rerun: got done=%0d writes=%0d want 1/%0d", done_cnt - d0,
                     wq.size() - w0, exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                n_cmp++;
                if (wq[w0 + i] !== exp_w[i]) begin
                    n_bad++;
                    $display("FAIL abort_rerun_wr[%0d]: got %h want %h", i, wq[w0 + i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit found;
        settle();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; start_layer = 3'd0; single = 1'b0;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (outs_all !== 55'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run: got %h want 0", outs_all);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; finish = 3'b001;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (en_conv == 3'b000) finish = '0;
            if (rd_addr == 16'd1 && rd_sel != 3'b000) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (!found || outs_all !== 55'd0) begin
            n_bad++;
            $display("FAIL reset_mid_copy: got %h (reached=%0d) want 0", outs_all, found);
        end
        finish = '1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({en_conv, rd_sel, wr_en, busy} !== 10'd0) begin
            n_bad++;
            $display("FAIL finish_in_idle: got %b want 0", {en_conv, rd_sel, wr_en, busy});
        end
        finish = '0;
        settle();
        n_cmp++;
        if (done_cnt - d0 !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt - d0);
        end
    endtask

    task automatic test_random();
        int w0, e0, d0, v0, bad0;
        bit to;
        logic [2:0] sl;
        logic sgl, relu;
        for (int it = 0; it < 10; it++) begin
            fill_mem();
            sl = 3'($urandom_range(0, 2));
            sgl = 1'($urandom);
            relu = 1'($urandom);
            settle();
            w0 = wq.size(); e0 = enq.size(); d0 = done_cnt; v0 = viol_cnt; bad0 = n_bad;
            do_run(sl, sgl, relu, 0, 1'b1, to);
            settle();
            settle();
            model_run(sl, sgl, relu);
            n_cmp++;
            if (to || done_cnt - d0 !== 1) begin
                n_bad++;
                $display("FAIL rand%0d_done: got %0d (timeout=%0d) want 1", it, done_cnt - d0, to);
            end
            n_cmp++;
            if (enq.size() - e0 !== exp_en.size() || wq.size() - w0 !== exp_w.size()) begin
                n_bad++;
                $display("FAIL rand%0d_counts: got en=%0d wr=%0d want %0d/%0d", it,
                         enq.size() - e0, wq.size() - w0, exp_en.size(), exp_w.size());
            end else begin
                for (int i = 0; i < exp_en.size(); i++) begin
                    n_cmp++;
                    if (enq[e0 + i] !== exp_en[i]) begin
                        n_bad++;
                        $display("FAIL rand%0d_en[%0d]: got %b want %b", it, i, enq[e0 + i],
                                 exp_en[i]);
                    end
                end
                for (int i = 0; i < exp_w.size(); i++) begin
                    n_cmp++;
                    if (wq[w0 + i] !== exp_w[i]) begin
                        n_bad++;
                        $display("FAIL rand%0d_wr[%0d]: got %h want %h", it, i, wq[w0 + i],
                                 exp_w[i]);
                    end
                end
            end
            n_cmp++;
            if (viol_cnt - v0 !== 0) begin
                n_bad++;
                $display("FAIL rand%0d_invariants: got %0d want 0", it, viol_cnt - v0);
            end
            if (n_bad != bad0) $display("  run %0d: start_layer=%0d single=%0d relu=%0d", it,
                                        sl, sgl, relu);
        end
    endtask

    initial begin
        test_reset();
        test_chain();
        test_relu();
        test_single();
        test_bad_start();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test want finish");
        $fatal(1);
    end

endmodule
